// File: rtl/storage_access_master.sv
// Strobe-interface master for a single storage register.
// Performs write, read and write-with-readback verify for a valid/ready command port.
module storage_access_master #(
  parameter int n   = 16,
  parameter int ECW = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_op,
  input  logic [n-1:0]   cmd_data,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [n-1:0]   rsp_data,
  output logic           rsp_err,
  output logic           mem_read,
  output logic           mem_write,
  output logic [n-1:0]   mem_wdata,
  input  logic [n-1:0]   mem_rdata,
  output logic           busy,
  output logic [ECW-1:0] err_count
);

  typedef enum logic [2:0] {
    IDLE, WR, RD, RD_CAP, RSP
  } state_e;

  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] OP_WV = 2'b11;

  state_e         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [n-1:0]   data_q, data_d;
  logic [n-1:0]   wdata_q, wdata_d;
  logic [n-1:0]   rdata_q, rdata_d;
  logic           err_q, err_d;
  logic [ECW-1:0] cnt_q, cnt_d;
  logic           miss;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      data_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign miss = (op_q == OP_WV) && (mem_rdata != data_q);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    data_d    = data_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          if (cmd_op == OP_WR || cmd_op == OP_WV) begin
            state_d = WR;
            wdata_d = cmd_data;
          end else if (cmd_op == OP_RD) begin
            state_d = RD;
          end
        end
      end
      WR: begin
        mem_write = 1'b1;
        if (op_q == OP_WR) begin
          state_d = RSP;
          rdata_d = data_q;
          err_d   = 1'b0;
        end else begin
          state_d = RD;
        end
      end
      RD: begin
        mem_read = 1'b1;
        state_d  = RD_CAP;
      end
      RD_CAP: begin
        rdata_d = mem_rdata;
        err_d   = miss;
        if (miss && (cnt_q != '1))
          cnt_d = cnt_q + ECW'(1);
        state_d = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_wdata = wdata_q;
  assign rsp_data  = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != IDLE);
  assign err_count = cnt_q;

endmodule

// File: tb/tb_storage_access_master.sv
// Randomised self-checking bench for storage_access_master.
// Reference model tracks storage contents, expected responses and latencies.
module tb_storage_access_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        mem_read, mem_write;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        busy;
  logic [7:0]  err_count;

  logic        c2_valid, c2_ready_o, c2_rsp_valid, c2_rsp_err;
  logic [1:0]  c2_op;
  logic [15:0] c2_data, c2_rsp_data, c2_wdata;
  logic [15:0] c2_rdata = '0;
  logic        c2_rsp_ready, c2_rd, c2_wr, c2_busy;
  logic [1:0]  c2_cnt;

  logic [15:0] store = '0;
  logic [15:0] store2 = '0;
  logic        fault = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;
  logic [15:0] ref_mem = '0;
  int ref_cnt = 0;

  always #5 clk = ~clk;

  storage_access_master #(.n(16), .ECW(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .err_count(err_count)
  );

  storage_access_master #(.n(16), .ECW(2)) dut2 (
    .clk(clk), .reset(reset),
    .cmd_valid(c2_valid), .cmd_ready(c2_ready_o),
    .cmd_op(c2_op), .cmd_data(c2_data),
    .rsp_valid(c2_rsp_valid), .rsp_ready(c2_rsp_ready),
    .rsp_data(c2_rsp_data), .rsp_err(c2_rsp_err),
    .mem_read(c2_rd), .mem_write(c2_wr),
    .mem_wdata(c2_wdata), .mem_rdata(c2_rdata),
    .busy(c2_busy), .err_count(c2_cnt)
  );

  // Storage models; the faulty one reads bit0 back stuck at zero.
  always @(posedge clk) begin
    if (mem_write) store <= mem_wdata;
    if (mem_read) mem_rdata <= fault ? (store & 16'hFFFE) : store;
  end

  always @(posedge clk) begin
    if (c2_wr) store2 <= c2_wdata;
    if (c2_rd) c2_rdata <= store2 ^ 16'h0001;
  end

  task automatic model(input logic [1:0] op, input logic [15:0] data,
                       output logic [15:0] d, output logic e,
                       output int lat, output int nwr, output int nrd);
    d = '0; e = 1'b0; lat = 0; nwr = 0; nrd = 0;
    case (op)
      2'd1: begin
        ref_mem = data; d = data; lat = 2; nwr = 1;
      end
      2'd2: begin
        d = fault ? (ref_mem & 16'hFFFE) : ref_mem;
        lat = 3; nrd = 1;
      end
      2'd3: begin
        ref_mem = data;
        d = fault ? (data & 16'hFFFE) : data;
        e = (d != data);
        if (e && ref_cnt < 255) ref_cnt++;
        lat = 4; nwr = 1; nrd = 1;
      end
      default: ;
    endcase
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] data,
                       input int stall, output int lat,
                       output logic [15:0] d, output logic e,
                       output int nwr, output int nrd,
                       output logic [15:0] wd, output bit ok);
    ok = 1; wd = '0;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; rsp_ready = 1'b0;
    if (!cmd_ready) ok = 0;
    @(posedge clk); #1;
    cmd_op = 2'($urandom); cmd_data = 16'($urandom);
    lat = 1; nwr = 0; nrd = 0;
    while (!rsp_valid && lat < 12) begin
      if (mem_write) wd = mem_wdata;
      if (mem_write && mem_read) ok = 0;
      nwr += int'(mem_write);
      nrd += int'(mem_read);
      if (cmd_ready || !busy) ok = 0;
      @(posedge clk); #1;
      lat++;
    end
    d = rsp_data; e = rsp_err;
    repeat (stall) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_data !== d || rsp_err !== e || cmd_ready) ok = 0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    if (rsp_valid || busy || !cmd_ready || rsp_data !== d) ok = 0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({busy, rsp_valid, rsp_err, mem_read, mem_write} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctl got %b want 00000",
               {busy, rsp_valid, rsp_err, mem_read, mem_write});
    end
    n_cmp++;
    if ({mem_wdata, rsp_data, err_count} !== 40'h0) begin
      n_fail++;
      $display("FAIL reset_data got %h/%h/%h want 0", mem_wdata, rsp_data, err_count);
    end
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write;
    int lat, nwr, nrd, el, ew, er;
    logic [15:0] d, wd, ed;
    logic e, ee;
    bit ok;
    model(2'd1, 16'h1234, ed, ee, el, ew, er);
    issue(2'd1, 16'h1234, 0, lat, d, e, nwr, nrd, wd, ok);
    n_cmp++;
    if (lat !== el || d !== ed || e !== ee) begin
      n_fail++;
      $display("FAIL write got lat=%0d d=%h e=%b want lat=%0d d=%h e=%b", lat, d, e, el, ed, ee);
    end
    n_cmp++;
    if (nwr !== ew || nrd !== er || wd !== 16'h1234 || !ok) begin
      n_fail++;
      $display("FAIL write_strb got wr=%0d rd=%0d wd=%h ok=%0d want %0d %0d 1234 1",
               nwr, nrd, wd, ok, ew, er);
    end
  endtask

  task automatic test_read;
    int lat, nwr, nrd, el, ew, er;
    logic [15:0] d, wd, ed;
    logic e, ee;
    bit ok;
    model(2'd2, 16'hFFFF, ed, ee, el, ew, er);
    issue(2'd2, 16'hFFFF, 0, lat, d, e, nwr, nrd, wd, ok);
    n_cmp++;
    if (lat !== el || d !== ed || e !== ee || d !== 16'h1234) begin
      n_fail++;
      $display("FAIL read got lat=%0d d=%h e=%b want lat=%0d d=%h", lat, d, e, el, ed);
    end
    n_cmp++;
    if (nwr !== 0 || nrd !== 1 || !ok) begin
      n_fail++;
      $display("FAIL read_strb got wr=%0d rd=%0d ok=%0d want 0 1 1", nwr, nrd, ok);
    end
  endtask

  task automatic test_verify;
    int lat, nwr, nrd, el, ew, er;
    logic [15:0] d, wd, ed;
    logic e, ee;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      fault = (k == 0);
      model(2'd3, 16'hBEEF, ed, ee, el, ew, er);
      issue(2'd3, 16'hBEEF, 0, lat, d, e, nwr, nrd, wd, ok);
      n_cmp++;
      if (lat !== el || d !== ed || e !== ee) begin
        n_fail++;
        $display("FAIL verify%0d got lat=%0d d=%h e=%b want lat=%0d d=%h e=%b",
                 k, lat, d, e, el, ed, ee);
      end
      n_cmp++;
      if (int'(err_count) !== ref_cnt || nwr !== 1 || nrd !== 1 || !ok) begin
        n_fail++;
        $display("FAIL verify%0d_cnt got cnt=%0d wr=%0d rd=%0d ok=%0d want cnt=%0d 1 1 1",
                 k, err_count, nwr, nrd, ok, ref_cnt);
      end
    end
    fault = 1'b0;
  endtask

  task automatic test_backpressure;
    int lat, nwr, nrd, el, ew, er;
    logic [15:0] d, wd, ed;
    logic e, ee;
    bit ok;
    model(2'd2, 16'h0, ed, ee, el, ew, er);
    issue(2'd2, 16'h0, 5, lat, d, e, nwr, nrd, wd, ok);
    n_cmp++;
    if (!ok || d !== ed || lat !== el) begin
      n_fail++;
      $display("FAIL backpressure got ok=%0d d=%h lat=%0d want 1 %h %0d", ok, d, lat, ed, el);
    end
    model(2'd1, 16'hA5A5, ed, ee, el, ew, er);
    issue(2'd1, 16'hA5A5, 0, lat, d, e, nwr, nrd, wd, ok);
    n_cmp++;
    if (!ok || d !== ed || lat !== el) begin
      n_fail++;
      $display("FAIL bp_next got ok=%0d d=%h lat=%0d want 1 %h %0d", ok, d, lat, ed, el);
    end
  endtask

  task automatic test_stream;
    int lat, nwr, nrd, el, ew, er;
    logic [15:0] d, wd, ed;
    logic e, ee;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 16'($urandom);
      @(posedge clk); #1;
      n_cmp++;
      if (busy || rsp_valid || mem_read || mem_write || !cmd_ready) begin
        n_fail++;
        $display("FAIL nop%0d got busy=%b rv=%b rd=%b wr=%b rdy=%b want 0 0 0 0 1",
                 k, busy, rsp_valid, mem_read, mem_write, cmd_ready);
      end
      if (k == 0) begin
        model(2'd1, 16'h00FF, ed, ee, el, ew, er);
        issue(2'd1, 16'h00FF, 0, lat, d, e, nwr, nrd, wd, ok);
      end else begin
        model(2'd2, 16'h0, ed, ee, el, ew, er);
        issue(2'd2, 16'h0, 0, lat, d, e, nwr, nrd, wd, ok);
      end
      n_cmp++;
      if (!ok || d !== ed || lat !== el || nwr !== ew || nrd !== er) begin
        n_fail++;
        $display("FAIL stream%0d got ok=%0d d=%h lat=%0d want 1 %h %0d", k, ok, d, lat, ed, el);
      end
    end
    n_cmp++;
    if (d !== 16'h00FF) begin
      n_fail++;
      $display("FAIL stream_rd got %h want 00ff", d);
    end
  endtask

  task automatic test_reset_mid;
    int lat, nwr, nrd, el, ew, er;
    logic [15:0] d, wd, ed;
    logic e, ee;
    bit ok;
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_data = 16'h0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (busy || rsp_valid || mem_read || mem_write || err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid got busy=%b rv=%b rd=%b wr=%b cnt=%0d want all 0",
               busy, rsp_valid, mem_read, mem_write, err_count);
    end
    ref_cnt = 0;
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    model(2'd1, 16'h5555, ed, ee, el, ew, er);
    issue(2'd1, 16'h5555, 0, lat, d, e, nwr, nrd, wd, ok);
    n_cmp++;
    if (!ok || d !== ed || lat !== el || wd !== 16'h5555) begin
      n_fail++;
      $display("FAIL reset_wr got ok=%0d d=%h lat=%0d wd=%h want 1 5555 %0d 5555",
               ok, d, lat, wd, el);
    end
  endtask

  task automatic test_random;
    int lat, nwr, nrd, el, ew, er, st;
    logic [15:0] d, wd, ed, dat;
    logic e, ee;
    logic [1:0] op;
    bit ok;
    for (int k = 0; k < 24; k++) begin
      op = 2'($urandom_range(1, 3));
      dat = 16'($urandom);
      fault = 1'($urandom);
      st = $urandom_range(0, 3);
      model(op, dat, ed, ee, el, ew, er);
      issue(op, dat, st, lat, d, e, nwr, nrd, wd, ok);
      n_cmp++;
      if (!ok || d !== ed || e !== ee || lat !== el || nwr !== ew || nrd !== er
          || int'(err_count) !== ref_cnt) begin
        n_fail++;
        $display("FAIL rand%0d op=%0d got ok=%0d d=%h e=%b lat=%0d cnt=%0d want %h %b %0d %0d",
                 k, op, ok, d, e, lat, err_count, ed, ee, el, ref_cnt);
      end
    end
    fault = 1'b0;
  endtask

  task automatic test_saturation;
    int w, exp_cnt;
    c2_rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      c2_valid = 1'b1; c2_op = 2'd3; c2_data = 16'($urandom);
      @(posedge clk); #1;
      c2_valid = 1'b0;
      w = 0;
      while (c2_busy && w < 10) begin
        @(posedge clk); #1;
        w++;
      end
      exp_cnt = (k + 1 > 3) ? 3 : k + 1;
      n_cmp++;
      if (int'(c2_cnt) !== exp_cnt || c2_rsp_err !== 1'b1 || w >= 10) begin
        n_fail++;
        $display("FAIL sat%0d got cnt=%0d err=%b wait=%0d want cnt=%0d err=1",
                 k, c2_cnt, c2_rsp_err, w, exp_cnt);
      end
    end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; rsp_ready = 1'b0;
    c2_valid = 1'b0; c2_op = '0; c2_data = '0; c2_rsp_ready = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_verify();
    test_backpressure();
    test_stream();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
